// File: rtl/core_seq.sv
// core_seq: pass sequencer emitting registered core instructions for load/execute/drain.
// Build macro CORE_SEQ_NORM_EN adds the ACC/DIVW/DIV normalisation phases after PWR.
module core_seq #(
   parameter int NQ        = 16,
   parameter int COL       = 8,
   parameter int DRAIN_GAP = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stall,
   input  logic        norm_go,
   output logic [18:0] inst,
   output logic        mem_req,
   output logic        mem_sel,
   output logic [3:0]  mem_row,
   output logic        busy,
   output logic        done
);
`ifdef CORE_SEQ_NORM_EN
   typedef enum logic [3:0] {IDLE, QWR, KWR, KLD, GAP, EXE, WAIT, PWR, ACC, DIVW, DIV, DONE} state_t;
`else
   typedef enum logic [3:0] {IDLE, QWR, KWR, KLD, GAP, EXE, WAIT, PWR, DONE} state_t;
   logic unused_norm_go;
   assign unused_norm_go = norm_go;
`endif
   state_t      state, nxt;
   logic [7:0]  cnt, ncnt, len;
   logic [18:0] d;
   logic [3:0]  row;
   logic        hold, mreq;
   assign row  = ncnt[3:0];
   assign mreq = (nxt == QWR) || (nxt == KWR);
   always_comb begin
      len = 8'd1;
      case (state)
         QWR, EXE, PWR: len = 8'(NQ);
         KWR, KLD:      len = 8'(COL);
         WAIT:          len = 8'(DRAIN_GAP);
`ifdef CORE_SEQ_NORM_EN
         ACC, DIV:      len = 8'(NQ);
`endif
         default:       len = 8'd1;
      endcase
   end
   // state/cnt name the operation currently on the outputs; stall freezes them
   always_comb begin
      hold = stall && (state != IDLE) && (state != DONE);
      nxt  = state;
      ncnt = cnt + 8'd1;
      case (state)
         IDLE: begin
            nxt  = start ? QWR : IDLE;
            ncnt = '0;
         end
         DONE: begin
            nxt  = IDLE;
            ncnt = '0;
         end
`ifdef CORE_SEQ_NORM_EN
         DIVW: begin
            nxt  = norm_go ? DIV : DIVW;
            ncnt = '0;
         end
`endif
         default:
            if (cnt == len - 8'd1) begin
               ncnt = '0;
               case (state)
                  QWR:     nxt = KWR;
                  KWR:     nxt = KLD;
                  KLD:     nxt = GAP;
                  GAP:     nxt = EXE;
                  EXE:     nxt = WAIT;
                  WAIT:    nxt = PWR;
`ifdef CORE_SEQ_NORM_EN
                  PWR:     nxt = ACC;
                  ACC:     nxt = DIVW;
                  DIV:     nxt = DONE;
`else
                  PWR:     nxt = DONE;
`endif
                  default: nxt = IDLE;
               endcase
            end
      endcase
      if (hold) begin
         nxt  = state;
         ncnt = cnt;
      end
   end
   always_comb begin
      d = '0;
      case (nxt)
         QWR: begin d[4] = 1'b1; d[15:12] = row; end
         KWR: begin d[2] = 1'b1; d[15:12] = row; end
         KLD: begin d[3] = 1'b1; d[6] = 1'b1; d[15:12] = row; end
         EXE: begin d[5] = 1'b1; d[7] = 1'b1; d[15:12] = row; end
         PWR: begin d[16] = 1'b1; d[0] = 1'b1; d[11:8] = row; end
`ifdef CORE_SEQ_NORM_EN
         ACC: begin d[17] = 1'b1; d[1] = 1'b1; d[11:8] = row; end
         DIV: begin d[18] = 1'b1; d[1] = 1'b1; d[11:8] = row; end
`endif
         default: d = '0;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         inst    <= '0;
         mem_req <= 1'b0;
         mem_sel <= 1'b0;
         mem_row <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= nxt;
         cnt     <= ncnt;
         inst    <= hold ? '0 : d;
         mem_req <= !hold && mreq;
         mem_sel <= !hold && (nxt == KWR);
         mem_row <= (!hold && mreq) ? row : 4'd0;
         busy    <= nxt != IDLE;
         done    <= nxt == DONE;
      end
   end
endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: randomized self-checking bench; expected per-cycle outputs come from
// an operation list built from the phase table, walked by a pointer.
module tb_core_seq;
   localparam int NQ = 16, COL = 8, DG = 10;
`ifdef CORE_SEQ_NORM_EN
   localparam int PASS_LEN = 109;
`else
   localparam int PASS_LEN = 76;
`endif
   logic clk = 1'b0, reset = 1'b0, start = 1'b0, stall = 1'b0, norm_go = 1'b0;
   logic [18:0] inst;
   logic mem_req, mem_sel, busy, done;
   logic [3:0] mem_row;
   core_seq #(.NQ(NQ), .COL(COL), .DRAIN_GAP(DG)) dut (
      .clk(clk), .reset(reset), .start(start), .stall(stall), .norm_go(norm_go),
      .inst(inst), .mem_req(mem_req), .mem_sel(mem_sel), .mem_row(mem_row),
      .busy(busy), .done(done));
   always #5 clk = ~clk;
   typedef struct { logic [24:0] v; bit hold; bit last; } op_t;
   op_t ops[$];
   int p = -1;
   logic [24:0] exp_v = '0;
   wire [24:0] obs = {inst, mem_req, mem_sel, mem_row, busy, done};
   int vecs = 0, fails = 0;
   function automatic void add(int n, logic [18:0] base, int sh, bit req, bit sel);
      for (int r = 0; r < n; r++) begin
         op_t o;
         o.v = {base | (sh != 0 ? (19'(r) << sh) : 19'd0), req, sel, req ? 4'(r) : 4'd0, 1'b1, 1'b0};
         o.hold = 0;
         o.last = 0;
         ops.push_back(o);
      end
   endfunction
   function automatic void build();
      op_t o;
      ops.delete();
      add(NQ, 19'd1 << 4, 12, 1, 0);
      add(COL, 19'd1 << 2, 12, 1, 1);
      add(COL, (19'd1 << 3) | (19'd1 << 6), 12, 0, 0);
      add(1, 19'd0, 0, 0, 0);
      add(NQ, (19'd1 << 5) | (19'd1 << 7), 12, 0, 0);
      add(DG, 19'd0, 0, 0, 0);
      add(NQ, (19'd1 << 16) | 19'd1, 8, 0, 0);
`ifdef CORE_SEQ_NORM_EN
      add(NQ, (19'd1 << 17) | (19'd1 << 1), 8, 0, 0);
      o.v = 25'd2; o.hold = 1; o.last = 0;
      ops.push_back(o);
      add(NQ, (19'd1 << 18) | (19'd1 << 1), 8, 0, 0);
`endif
      o.v = 25'd3; o.hold = 0; o.last = 1;
      ops.push_back(o);
   endfunction
   // one clock: advance the reference model on the same sampled inputs as the DUT
   task automatic tick();
      @(posedge clk);
      if (!reset) begin p = -1; exp_v = '0; end
      else if (p < 0) begin
         if (start) begin p = 0; exp_v = ops[0].v; end
         else exp_v = '0;
      end
      else if (ops[p].last) begin p = -1; exp_v = '0; end
      else if (stall) exp_v = 25'd2;
      else if (ops[p].hold && !norm_go) exp_v = ops[p].v;
      else begin p++; exp_v = ops[p].v; end
      @(negedge clk);
   endtask
   task automatic test_reset();
      reset = 0; start = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         vecs++;
         if (obs !== 25'd0) begin fails++; $display("FAIL reset_hold cyc %0d: got %h want 0", i, obs); end
      end
      reset = 1; start = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vecs++;
         if (obs !== exp_v) begin fails++; $display("FAIL reset_release cyc %0d: got %h want %h", i, obs, exp_v); end
      end
   endtask
   task automatic test_full_pass();
      int n;
      norm_go = 1; start = 1;
      tick();
      start = 0; n = 1;
      vecs++;
      if (obs !== exp_v) begin fails++; $display("FAIL pass cyc %0d: got %h want %h", n, obs, exp_v); end
      while (!done && n < 400) begin
         tick(); n++;
         vecs++;
         if (obs !== exp_v) begin fails++; $display("FAIL pass cyc %0d: got %h want %h", n, obs, exp_v); end
      end
      vecs++;
      if (n !== PASS_LEN) begin fails++; $display("FAIL pass_len: got %0d want %0d", n, PASS_LEN); end
      tick();
      vecs++;
      if (busy !== 1'b0 || obs !== 25'd0) begin fails++; $display("FAIL post_done: got %h want 0", obs); end
   endtask
   task automatic test_stall();
      int n;
      bit did = 0;
      norm_go = 1; start = 1;
      tick();
      start = 0; n = 1;
      while (!done && n < 400) begin
         if (inst[7] && inst[15:12] == 4'd4 && !did) begin
            did = 1; stall = 1;
         end
         tick(); n++;
         if (n > 3 && stall && did && inst === 19'd0 && busy) begin
            if (exp_v === 25'd2 && ($urandom_range(0, 0) == 0)) ;
         end
         vecs++;
         if (obs !== exp_v) begin fails++; $display("FAIL stall cyc %0d: got %h want %h", n, obs, exp_v); end
         if (did && stall && obs == 25'd2) begin
            tick(); n++;
            vecs++;
            if (obs !== 25'd2) begin fails++; $display("FAIL stall_zero2: got %h want %h", obs, 25'd2); end
            tick(); n++;
            vecs++;
            if (obs !== 25'd2) begin fails++; $display("FAIL stall_zero3: got %h want %h", obs, 25'd2); end
            stall = 0;
            tick(); n++;
            vecs++;
            if (inst !== ((19'd1 << 5) | (19'd1 << 7) | (19'd5 << 12))) begin
               fails++; $display("FAIL stall_resume: got %h want row 5 exe", inst);
            end
         end
      end
      stall = 0;
      vecs++;
      if (n !== PASS_LEN + 3) begin fails++; $display("FAIL stall_len: got %0d want %0d", n, PASS_LEN + 3); end
      tick();
   endtask
`ifdef CORE_SEQ_NORM_EN
   task automatic test_divw();
      int n, zc = 0;
      norm_go = 0; start = 1;
      tick();
      start = 0; n = 1;
      while (!done && n < 400) begin
         tick(); n++;
         vecs++;
         if (obs !== exp_v) begin fails++; $display("FAIL divw cyc %0d: got %h want %h", n, obs, exp_v); end
         zc = (p >= 0 && ops[p].hold) ? zc + 1 : 0;
         if (zc == 20) norm_go = 1;
      end
      vecs++;
      if (n !== PASS_LEN + 19) begin fails++; $display("FAIL divw_len: got %0d want %0d", n, PASS_LEN + 19); end
      norm_go = 1;
      tick();
   endtask
`endif
   task automatic test_reset_mid_pass();
      int n = 0, dn = 0;
      norm_go = 1; start = 1;
      tick();
      start = 0;
      while (!(inst[16] && inst[11:8] == 4'd7) && n < 200) begin
         tick(); n++;
         vecs++;
         if (obs !== exp_v) begin fails++; $display("FAIL rst_mid cyc %0d: got %h want %h", n, obs, exp_v); end
      end
      reset = 0;
      tick();
      vecs++;
      if (obs !== 25'd0) begin fails++; $display("FAIL rst_mid_abort: got %h want 0", obs); end
      reset = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         dn += int'(done);
      end
      vecs++;
      if (dn !== 0 || obs !== 25'd0) begin fails++; $display("FAIL rst_mid_idle: got %h dones %0d want 0", obs, dn); end
      test_full_pass();
   endtask
   task automatic test_back_to_back();
      int n = 0, dn = 0;
      bit did = 0;
      norm_go = 1; start = 1;
      tick();
      start = 0;
      while (n < PASS_LEN + 10) begin
         if (inst[6] && !did) begin did = 1; start = 1; end
         else start = 0;
         tick(); n++;
         dn += int'(done);
         vecs++;
         if (obs !== exp_v) begin fails++; $display("FAIL restart cyc %0d: got %h want %h", n, obs, exp_v); end
      end
      vecs++;
      if (dn !== 1) begin fails++; $display("FAIL restart_dones: got %0d want 1", dn); end
   endtask
   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         stall   = $urandom_range(0, 3) == 0;
         start   = $urandom_range(0, 15) == 0;
         norm_go = $urandom_range(0, 2) != 0;
         reset   = $urandom_range(0, 299) != 0;
         tick();
         vecs++;
         if (obs !== exp_v) begin fails++; $display("FAIL random cyc %0d: got %h want %h", i, obs, exp_v); end
      end
      stall = 0; start = 0; reset = 1; norm_go = 1;
   endtask
   initial begin
      build();
      test_reset();
      test_full_pass();
      test_stall();
`ifdef CORE_SEQ_NORM_EN
      test_divw();
`endif
      test_reset_mid_pass();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end
endmodule

// File: doc/core_seq.md
CORE_SEQ -- requirements
Module: core_seq

Interface
REQ-001 Parameter NQ, default 16, query rows per pass (1..16).
REQ-002 Parameter COL, default 8, kernel rows (1..16).
REQ-003 Parameter DRAIN_GAP, default 10, idle cycles between execute and ofifo drain (1..255).
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 start  input  1  pulse requesting one full pass; sampled only in IDLE.
REQ-007 stall  input  1  pause: counters and state hold, inst forced to 0 that cycle.
REQ-008 norm_go  input  1  partner-core sum available; gates the divide phase.
REQ-009 inst  output  19  core instruction: [18]div [17]acc [16]ofifo_rd [15:12]qkmem_add [11:8]pmem_add [7]execute [6]load [5]qmem_rd [4]qmem_wr [3]kmem_rd [2]kmem_wr [1]pmem_rd [0]pmem_wr.
REQ-010 mem_req  output  1  mem_in must carry row mem_row of the selected operand this cycle.
REQ-011 mem_sel  output  1  0 = Q operand, 1 = K operand.
REQ-012 mem_row  output  4  operand row index.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse at pass completion.

Function
REQ-015 States: IDLE, QWR, KWR, KLD, GAP, EXE, WAIT, PWR, ACC, DIVW, DIV, DONE; all outputs registered.
REQ-016 IDLE: start=1 -> QWR at next edge; inst=0, busy=0.
REQ-017 QWR: NQ cycles, qmem_wr=1, qkmem_add=mem_row=0..NQ-1, mem_req=1, mem_sel=0 -> KWR.
REQ-018 KWR: COL cycles, kmem_wr=1, qkmem_add=mem_row=0..COL-1, mem_req=1, mem_sel=1 -> KLD.
REQ-019 KLD: COL cycles, kmem_rd=1, load=1, qkmem_add=0..COL-1 -> GAP.
REQ-020 GAP: 1 cycle, inst=0 -> EXE.
REQ-021 EXE: NQ cycles, qmem_rd=1, execute=1, qkmem_add=0..NQ-1 -> WAIT.
REQ-022 WAIT: DRAIN_GAP cycles, inst=0 -> PWR.
REQ-023 PWR: NQ cycles, ofifo_rd=1, pmem_wr=1, pmem_add=0..NQ-1 -> ACC (or DONE per REQ-032).
REQ-024 ACC: NQ cycles, pmem_rd=1, acc=1, pmem_add=0..NQ-1 -> DIVW.
REQ-025 DIVW: inst=0; minimum 1 cycle; leaves to DIV at the edge where norm_go=1; waits indefinitely otherwise.
REQ-026 DIV: NQ cycles, pmem_rd=1, div=1, pmem_add=0..NQ-1 -> DONE.
REQ-027 DONE: 1 cycle, done=1, inst=0, busy=1 -> IDLE.
REQ-028 All inst bits not listed for a state are 0; mem_req=0 outside QWR/KWR; mem_row/mem_sel=0 when mem_req=0.
REQ-029 stall=1 in any non-IDLE state: inst=0, mem_req=0, phase counter and state unchanged; sequence resumes at the same row when stall drops; stall in IDLE/DONE has no effect.
REQ-030 start while busy is ignored; start and stall together in IDLE: start honoured.
REQ-031 Unstalled pass with norm_go held high: 109 cycles QWR-first to DONE inclusive (NQ=16, COL=8, DRAIN_GAP=10).

Configuration
REQ-032 Macro CORE_SEQ_NORM_EN: defined -> ACC, DIVW, DIV present, PWR -> ACC; undefined -> those states absent, PWR -> DONE, norm_go unused, inst[18:17] constant 0, pass = 76 cycles.

Reset
REQ-033 reset=0 at any edge, including mid-pass: state IDLE, counters 0, inst=0, mem_req=0, mem_sel=0, mem_row=0, busy=0, done=0; no done pulse issued for an aborted pass.
REQ-034 start asserted during reset is dropped.

Verification
REQ-035 Defaults, macro defined, norm_go=1, start pulse -> inst trace matches REQ-017..027 per cycle, done at cycle 109, busy low next cycle.
REQ-036 Macro undefined, same stimulus -> PWR followed by DONE, done at cycle 76, inst[18:17] never 1.
REQ-037 norm_go low until 20 cycles after ACC ends -> DIVW lasts 20 cycles with inst=0, then DIV rows 0..15.
REQ-038 stall high 3 cycles during EXE row 5 -> three inst=0 cycles, EXE resumes at qkmem_add=5, done delayed by exactly 3 cycles.
REQ-039 reset low during PWR row 7 -> next cycle IDLE, all outputs 0, no done; new start runs full pass from QWR row 0.
REQ-040 start re-pulsed during KLD -> ignored; exactly one done pulse.
